ddr_clk_div_gen: RTL

- Synthesizable, parametrised successor to the controller clock generator.
- Derives NUM_CH divided clocks and one-cycle strobes from the single controller clock CK_t. Each channel has its own run-time programmable divide ratio and phase offset; the half-rate CK_r is channel 0 at divide 2.
- Sits beside the controller and drives rate-domain enables for the command, data and refresh paths. Divide changes apply glitch-free at period boundaries.

---
 rtl/ddr_pkg.sv | 14 +
 rtl/ddr_clk_div_ch.sv | 68 ++++++
 rtl/ddr_clk_div_gen.sv | 116 +++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR controller clock generator.
// The config record is declared in ddr_clk_div_gen, where its field widths are known.
package ddr_pkg;

  localparam int CLK_DIV_MIN = 2;
  localparam int CLK_DEF_DIV = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } clk_gen_state_e;

endpackage

// File: rtl/ddr_clk_div_ch.sv
// One derived clock channel: divide/phase registers, period counter,
// wrap-aligned config apply and the clock/strobe decode.
module ddr_clk_div_ch #(
  parameter int DIV_W   = 4,
  parameter int DEF_DIV = 2
) (
  input  logic             CK_t,
  input  logic             reset,
  input  logic             run_cur,
  input  logic             run_nxt,
  input  logic             upd,
  input  logic [DIV_W-1:0] new_div,
  input  logic [DIV_W-1:0] new_phase,
  output logic             applied,
  output logic             ck_div,
  output logic             stb
);

  logic [DIV_W-1:0] cnt_r, div_r, ph_r;
  logic [DIV_W-1:0] cnt_nxt_s, div_nxt_s, ph_nxt_s, init_s;
  logic             at_wrap_s, apply_s;

  // Next divide/phase/counter; a new config lands only on the last count of a period.
  always_comb begin
    at_wrap_s = (cnt_r == (div_r - DIV_W'(1)));
    apply_s   = upd && (!run_cur || at_wrap_s);
    if (apply_s) begin
      div_nxt_s = new_div;
      ph_nxt_s  = new_phase;
    end else begin
      div_nxt_s = div_r;
      ph_nxt_s  = ph_r;
    end
    // Starting at div-ph puts the first strobe ph cycles into RUN.
    if (ph_nxt_s == {DIV_W{1'b0}}) begin
      init_s = {DIV_W{1'b0}};
    end else begin
      init_s = div_nxt_s - ph_nxt_s;
    end
    if (!run_nxt) begin
      cnt_nxt_s = {DIV_W{1'b0}};
    end else if (!run_cur || apply_s) begin
      cnt_nxt_s = init_s;
    end else if (at_wrap_s) begin
      cnt_nxt_s = {DIV_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + DIV_W'(1);
    end
  end

  // Channel state registers.
  always_ff @(posedge CK_t) begin
    if (reset) begin
      cnt_r <= {DIV_W{1'b0}};
      div_r <= DIV_W'(DEF_DIV);
      ph_r  <= {DIV_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
      div_r <= div_nxt_s;
      ph_r  <= ph_nxt_s;
    end
  end

  assign applied = apply_s;
  assign stb     = run_cur && (cnt_r == {DIV_W{1'b0}});
  assign ck_div  = run_cur && (cnt_r < (div_r >> 1'b1));

endmodule

// File: rtl/ddr_clk_div_gen.sv
// Controller clock generator: run FSM, single-slot config shadow with
// sanitising, and one ddr_clk_div_ch per derived channel.
module ddr_clk_div_gen
  import ddr_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 4,
  parameter int DEF_DIV = CLK_DEF_DIV,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CK_t,
  input  logic              reset,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] ck_div,
  output logic [NUM_CH-1:0] stb,
  output logic              locked,
  output logic              cfg_err
);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] phase;
  } clk_cfg_t;

  clk_gen_state_e    state_r, state_nxt_s;
  clk_cfg_t          shadow_r;
  logic              pending_r, cfg_err_r;
  logic [DIV_W-1:0]  san_div_s, san_phase_s;
  logic              div_bad_s, phase_bad_s, ch_bad_s, accept_s;
  logic [NUM_CH-1:0] upd_sel_s, applied_s;
  logic              run_cur_s, run_nxt_s;

  // Next-state logic; dropping en leaves ALIGN or RUN immediately.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = en ? ALIGN : IDLE;
      ALIGN:   state_nxt_s = en ? RUN : IDLE;
      RUN:     state_nxt_s = en ? RUN : IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sanitise the incoming request before it reaches the shadow slot.
  always_comb begin
    div_bad_s = (cfg_div < DIV_W'(CLK_DIV_MIN));
    if (div_bad_s) begin
      san_div_s = DIV_W'(CLK_DIV_MIN);
    end else begin
      san_div_s = cfg_div;
    end
    phase_bad_s = (cfg_phase >= san_div_s);
    if (phase_bad_s) begin
      san_phase_s = {DIV_W{1'b0}};
    end else begin
      san_phase_s = cfg_phase;
    end
    ch_bad_s = ({1'b0, cfg_ch} >= (CH_W+1)'(NUM_CH));
    accept_s = cfg_valid && !pending_r;
  end

  // FSM, shadow slot and error pulse registers.
  always_ff @(posedge CK_t) begin
    if (reset) begin
      state_r   <= IDLE;
      pending_r <= 1'b0;
      shadow_r  <= '{ch: {CH_W{1'b0}}, div: {DIV_W{1'b0}}, phase: {DIV_W{1'b0}}};
      cfg_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cfg_err_r <= accept_s && (div_bad_s || phase_bad_s || ch_bad_s);
      if (accept_s && !ch_bad_s) begin
        pending_r <= 1'b1;
        shadow_r  <= '{ch: cfg_ch, div: san_div_s, phase: san_phase_s};
      end else if (|applied_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  assign run_cur_s = (state_r == RUN);
  assign run_nxt_s = (state_nxt_s == RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign upd_sel_s[i] = pending_r && (shadow_r.ch == CH_W'(i));

    ddr_clk_div_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .CK_t      (CK_t),
      .reset     (reset),
      .run_cur   (run_cur_s),
      .run_nxt   (run_nxt_s),
      .upd       (upd_sel_s[i]),
      .new_div   (shadow_r.div),
      .new_phase (shadow_r.phase),
      .applied   (applied_s[i]),
      .ck_div    (ck_div[i]),
      .stb       (stb[i])
    );
  end

  assign locked    = run_cur_s;
  assign cfg_ready = !pending_r;
  assign cfg_err   = cfg_err_r;

endmodule
